smg_scan_arb_zyq: RTL
=====================

SMG_SCAN_ARB_ZYQ -- requirements
Module: smg_scan_arb_zyq

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit dwell; legal range 2..65535.
REQ-002 Parameter BLANK, default 4: blanking cycles at the start of each dwell; legal range 0..DIV-1.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; asynchronous and active-low.
REQ-005 req0  input  1  requester 0 asks to load a new display word.
REQ-006 data0  input  32  requester 0 display word; nibble k is shown on digit k.
REQ-007 req1  input  1  requester 1 asks to load a new display word.
REQ-008 data1  input  32  requester 1 display word.
REQ-009 gnt0  output  1  one-cycle pulse: data0 is captured at this edge.
REQ-010 gnt1  output  1  one-cycle pulse: data1 is captured at this edge.
REQ-011 sel  output  3  index of the digit currently scanned, for the 3-8 decoder.
REQ-012 nibble  output  4  held-buffer nibble for digit sel, for the 4-7 decoder.
REQ-013 blank  output  1  high means the digit is dark (segments and chip-select off).
REQ-014 frame  output  1  one-cycle pulse in the final cycle of digit 7.

Function
REQ-015 Prescaler pcnt counts 0..DIV-1 and wraps to 0; sel increments when pcnt==DIV-1; sel wraps 7->0.
REQ-016 blank is 1 while pcnt<BLANK, else 0; with BLANK=0 the display is never blanked by the prescaler.
REQ-017 nibble equals buf[4*sel+3:4*sel] combinationally from the registered sel and buf.
REQ-018 Frame boundary FB: pcnt==DIV-1 and sel==7; frame is high exactly in FB cycles.
REQ-019 Arbitration occurs only in FB cycles; requests outside FB wait, so the display never tears mid-frame.
REQ-020 In FB, exactly one request is granted: if only reqN is high, reqN wins; if both are high, the requester not granted last wins.
REQ-021 gntN is combinational (Mealy) in the FB cycle; buf loads dataN at the closing edge; last-grant register updates to N.
REQ-022 If neither request is high in FB, buf and the last-grant register hold and no grant pulses.
REQ-023 gnt0 and gnt1 are never high together; each is high for at most one cycle per frame.
REQ-024 Requesters hold req and data stable until their grant; deasserting req before FB withdraws the request without side effects.
REQ-025 A new word first becomes visible on digit 0 in the cycle after the grant.
REQ-026 Parameter-derived widths: pcnt is 16 bits; no truncation occurs for legal DIV.

Reset
REQ-027 While RST=0: pcnt=0, sel=0, buf=0, last-grant=1 (so requester 0 wins the first tie), gnt0=gnt1=0, frame=0.
REQ-028 Outputs in reset: sel=0, nibble=0, blank=1 if BLANK>0 else 0.
REQ-029 Reset asserted mid-frame or mid-grant aborts immediately; a pending request is re-arbitrated at the first FB after release.

Configuration
REQ-030 Macro SMG_LEADZERO_BLANK_EN compiled in: blank is also 1 for any digit sel>0 whose nibble and all higher nibbles of buf are 0; digit 0 is never suppressed this way.
REQ-031 Macro absent: blank depends only on REQ-016; all eight digits always show.

Verification (DIV=4, BLANK=1 unless noted)
REQ-032 Release reset, no requests -> sel steps 0..7 every 4 cycles; blank high when pcnt==0; frame pulses every 32 cycles; nibble=0.
REQ-033 req0=1, data0=32'h87654321 mid-frame -> gnt0 only in the next FB cycle; from the next cycle digit k shows nibble k+1 (sel=0 -> 1, sel=7 -> 8).
REQ-034 req0 and req1 both held across three FBs -> grants gnt0, gnt1, gnt0; never both high together.
REQ-035 req1 pulsed high for 2 cycles outside FB -> no gnt1; buf unchanged.
REQ-036 RST low for 1 cycle during sel=5 -> sel=0, buf=0 immediately; the held req0 is granted at the first FB after release.
REQ-037 SMG_LEADZERO_BLANK_EN defined, buf=32'h00000A05 -> blank=1 for sel 3..7 at all pcnt; sel 0..2 blank only at pcnt==0; macro absent -> sel 3..7 blank only at pcnt==0.

Source files
------------

// File: rtl/smg_scan_arb_zyq.sv
// Eight-digit multiplexed display scanner with a two-requester, frame-aligned buffer arbiter.
// Optional macro SMG_LEADZERO_BLANK_EN darkens leading-zero digits above digit 0.
module smg_scan_arb_zyq #(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned BLANK = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0,
   input  logic [31:0] data0,
   input  logic        req1,
   input  logic [31:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [2:0]  sel,
   output logic [3:0]  nibble,
   output logic        blank,
   output logic        frame
);

   localparam logic [15:0] PMAX = 16'(DIV - 1);

   logic [15:0] pcnt;
   logic [31:0] disp_buf;
   logic        last_gnt;
   logic        fb;
   logic        pre_blank;
   logic [31:0] upper;

   // Prescaler and digit select
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pcnt <= '0;
         sel  <= '0;
      end else if (pcnt == PMAX) begin
         pcnt <= '0;
         sel  <= sel + 3'd1;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

   assign fb    = (pcnt == PMAX) && (sel == 3'd7);
   assign frame = fb;

   // Grants are Mealy so the buffer swaps exactly at the frame-closing edge
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (fb) begin
         if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // last_gnt resets to 1 so requester 0 wins the first tie
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         disp_buf <= '0;
         last_gnt <= 1'b1;
      end else if (gnt0) begin
         disp_buf <= data0;
         last_gnt <= 1'b0;
      end else if (gnt1) begin
         disp_buf <= data1;
         last_gnt <= 1'b1;
      end
   end

   assign upper  = disp_buf >> {sel, 2'b00};
   assign nibble = upper[3:0];

   generate
      if (BLANK == 0) begin : g_no_blank
         assign pre_blank = 1'b0;
      end else begin : g_blank
         assign pre_blank = (pcnt < 16'(BLANK));
      end
   endgenerate

`ifdef SMG_LEADZERO_BLANK_EN
   // Digit is a leading zero when it and every higher nibble are zero
   assign blank = pre_blank || ((sel != 3'd0) && (upper == 32'd0));
`else
   assign blank = pre_blank;
`endif

endmodule
